top_conv_layer2: RTL and testbench
==================================

// Module: top_conv_layer2
// PURPOSE
//  CNN layer-2 convolution engine: 4 input activation rows x 12 channels, 3 kernel rows x 12 channels.
//  Computes 2 vertically adjacent output rows (row-stationary, 3x3 window, width streamed over 3 beats).
//  Tracks a running max of each output row for downstream 2D pooling; pool_end closes a pooling group.
// PARAMETERS
//  LANES    12  channels per input word
//  AW        8  activation width (unsigned)
//  WW        4  weight width (two's complement signed)
//  PW       24  psum/result field width (signed)
//  KW        3  kernel width = accepted beats per window
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous reset, active-high
//  en            in   1   global enable; low = freeze all state, ignore din_valid/pool_end
//  din_valid     in   1   beat qualifier, level-sensitive; beat accepted each clk with en&&din_valid
//  pool_end      in   1   1-cycle pulse; closes current pooling group
//  data_in_0..3  in   96  activation rows r=0..3; lane c = bits[8c+7:8c]
//  Filtr_in_0..2 in   48  kernel rows k=0..2; lane c = bits[4c+3:4c]
//  Psum_d_out    out  96  {max1, max0, psum1, psum0}, 24b signed each, psum0 at [23:0]
//  conv_counter  out  3   completed windows in current pooling group, saturates at 7
//  dout_vald     out  1   1-cycle strobe: Psum_d_out carries a new completed window
// BEHAVIOUR
//  - Reset (sync, rst=1): beat counter, accumulators, Psum_d_out, conv_counter, dout_vald all 0;
//    running maxes to most-negative 24b value (0x800000 internally; reported fields 0 until 1st window).
//  - Per accepted beat: term_o = sum_{k=0..2} sum_{c=0..11} data_in_{o+k}[c] * Filtr_in_k[c], o in {0,1}.
//    Product = zero-extended 8b x sign-extended 4b -> 13b signed; beat term 19b signed,
//    sign-extended to 24b and added to acc_o. No saturation needed (|window| < 2^18).
//  - Beat counter 0..2; on 3rd accepted beat (counter==2): psum_o <= acc_o + term_o,
//    max_o <= max(max_o, psum_o new), acc_o <= 0, counter <= 0, dout_vald <= 1 next cycle
//    (registered; latency 1 clk after 3rd beat). conv_counter += 1, saturating at 7.
//  - dout_vald high exactly one cycle per window; 0 otherwise. Psum_d_out holds last values between strobes.
//  - pool_end (en=1): maxes <= most-negative, conv_counter <= 0, beat counter and accs <= 0
//    (partial window discarded). Psum_d_out psum fields keep last value; max fields read 0.
//  - Priority: rst > !en (freeze) > pool_end > beat. Beat coinciding with pool_end is dropped.
//  - en low mid-window: partial accumulation retained; resumes on next accepted beat.
//  - rst mid-window: all state cleared; no dout_vald for the partial window.
//  - Non-beat cycles (din_valid low) change nothing; back-to-back beats every clk supported.
// STRUCTURE
//  - Shared package: LANES, AW, WW, PW, KW constants; lane-slice helper function; PSUM_MIN constant.
//  - One sub-module: conv_row_dot -- combinational 3-row x 12-lane signed dot product (19b out),
//    instantiated twice (o=0 uses rows 0-2, o=1 uses rows 1-3). Top holds counters, accs, max, output regs.
// TESTING
//  1. rst held 2 clk -> Psum_d_out=0, conv_counter=0, dout_vald=0.
//  2. data_in_0 all lanes 1, rows 1-3 = 0, all weights +1, 3 beats -> dout_vald 1 clk after
//     3rd beat, psum0=36, psum1=0, max0=36, max1=0, conv_counter=1.
//  3. Same but weights all 4'hF (-1) -> psum0=-36 (24'hFFFFDC); max0=-36.
//  4. din_valid toggling every clk for 12 clk (6 beats) -> exactly 2 dout_vald pulses, conv_counter=2;
//     then pool_end pulse -> conv_counter=0, max fields 0, psum fields unchanged.
//  5. Data lanes 255, weights -8, 3 beats -> psum0=psum1=-220320; no overflow.
//  6. 2 beats, pool_end, 3 beats (data_in_0 lanes 1, weights 1) -> psum0=36 (partial discarded);
//     en=0 during a beat -> beat ignored; 8+ windows -> conv_counter stays 7.

Source files
------------

// File: rtl/top_conv_layer2_pkg.sv
// Shared constants and lane-slicing helpers for the layer-2 convolution engine.
package top_conv_layer2_pkg;
  localparam int LANES  = 12;
  localparam int AW     = 8;
  localparam int WW     = 4;
  localparam int PW     = 24;
  localparam int KW     = 3;
  localparam int TW     = 19;
  localparam int PROD_W = AW + WW + 1;
  localparam int ROW_W  = LANES * AW;
  localparam int KROW_W = LANES * WW;

  // Most-negative psum: the identity for a running max.
  localparam logic signed [PW-1:0] PSUM_MIN = {1'b1, {(PW-1){1'b0}}};

  // Activation lane c of a packed row.
  function automatic logic [AW-1:0] act_lane(input logic [ROW_W-1:0] row, input int c);
    return row[c*AW +: AW];
  endfunction

  // Weight lane c of a packed kernel row.
  function automatic logic [WW-1:0] wt_lane(input logic [KROW_W-1:0] row, input int c);
    return row[c*WW +: WW];
  endfunction
endpackage

// File: rtl/top_conv_layer2_if.sv
// Stream bundle for the convolution engine.
// Handshake: din_valid is a level qualifier with no back-pressure; a beat is
// taken on every rising edge where en && din_valid && !pool_end. dout_vald is
// a one-cycle strobe marking a freshly completed window on Psum_d_out.
interface top_conv_layer2_if;
  import top_conv_layer2_pkg::*;

  logic              en;
  logic              din_valid;
  logic              pool_end;
  logic [ROW_W-1:0]  data_in_0;
  logic [ROW_W-1:0]  data_in_1;
  logic [ROW_W-1:0]  data_in_2;
  logic [ROW_W-1:0]  data_in_3;
  logic [KROW_W-1:0] Filtr_in_0;
  logic [KROW_W-1:0] Filtr_in_1;
  logic [KROW_W-1:0] Filtr_in_2;
  logic [4*PW-1:0]   Psum_d_out;
  logic [2:0]        conv_counter;
  logic              dout_vald;
  logic [1:0]        dbg_beat_cnt;

  modport master (
    output en, din_valid, pool_end,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output Filtr_in_0, Filtr_in_1, Filtr_in_2,
    input  Psum_d_out, conv_counter, dout_vald, dbg_beat_cnt
  );

  modport slave (
    input  en, din_valid, pool_end,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  Filtr_in_0, Filtr_in_1, Filtr_in_2,
    output Psum_d_out, conv_counter, dout_vald, dbg_beat_cnt
  );
endinterface

// File: rtl/top_conv_layer2_conv_row_dot.sv
// Combinational 3-row x 12-lane dot product of unsigned activations with
// signed 4-bit weights; one output row's contribution for a single beat.
module conv_row_dot
  import top_conv_layer2_pkg::*;
(
  input  logic [ROW_W-1:0]         row_0,
  input  logic [ROW_W-1:0]         row_1,
  input  logic [ROW_W-1:0]         row_2,
  input  logic [KROW_W-1:0]        w_0,
  input  logic [KROW_W-1:0]        w_1,
  input  logic [KROW_W-1:0]        w_2,
  output logic signed [TW-1:0]     dot
);

  // One kernel row: zero-extend activation, sign-extend weight, sum 12 products.
  function automatic logic signed [TW-1:0] row_sum(input logic [ROW_W-1:0] row,
                                                   input logic [KROW_W-1:0] wrow);
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic [WW-1:0]            wt;
    logic signed [TW-1:0]     s;
    s = '0;
    for (int c = 0; c < LANES; c++) begin
      wt    = wt_lane(wrow, c);
      a_ext = {{(PROD_W-AW){1'b0}}, act_lane(row, c)};
      w_ext = {{(PROD_W-WW){wt[WW-1]}}, wt};
      prod  = a_ext * w_ext;
      s     = s + {{(TW-PROD_W){prod[PROD_W-1]}}, prod};
    end
    return s;
  endfunction

  // Sum the three kernel rows for this output row.
  always_comb begin
    dot = row_sum(row_0, w_0) + row_sum(row_1, w_1) + row_sum(row_2, w_2);
  end

endmodule

// File: rtl/top_conv_layer2.sv
// Layer-2 convolution engine: two vertically adjacent output rows, each
// accumulated over three beats, with a running max per row for pooling.
module top_conv_layer2
  import top_conv_layer2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  top_conv_layer2_if.slave  bus
);

  localparam logic [1:0] BEAT_FIRST = 2'd0;
  localparam logic [1:0] BEAT_LAST  = 2'd2;

  logic [1:0]           beat_cnt;
  logic signed [PW-1:0] acc0, acc1;
  logic signed [PW-1:0] psum0, psum1;
  logic signed [PW-1:0] max0, max1;
  logic signed [PW-1:0] win0, win1;
  logic signed [TW-1:0] term0, term1;
  logic                 max_seen;
  logic [2:0]           conv_cnt;
  logic                 vald;

  conv_row_dot u_dot0 (
    .row_0 (bus.data_in_0), .row_1 (bus.data_in_1), .row_2 (bus.data_in_2),
    .w_0   (bus.Filtr_in_0), .w_1 (bus.Filtr_in_1), .w_2 (bus.Filtr_in_2),
    .dot   (term0)
  );

  conv_row_dot u_dot1 (
    .row_0 (bus.data_in_1), .row_1 (bus.data_in_2), .row_2 (bus.data_in_3),
    .w_0   (bus.Filtr_in_0), .w_1 (bus.Filtr_in_1), .w_2 (bus.Filtr_in_2),
    .dot   (term1)
  );

  // Window totals including the current beat's term.
  always_comb begin
    win0 = acc0 + {{(PW-TW){term0[TW-1]}}, term0};
    win1 = acc1 + {{(PW-TW){term1[TW-1]}}, term1};
  end

  // Beat counter, accumulators, running max, window outputs and strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= BEAT_FIRST;
      acc0     <= '0;
      acc1     <= '0;
      psum0    <= '0;
      psum1    <= '0;
      max0     <= PSUM_MIN;
      max1     <= PSUM_MIN;
      max_seen <= 1'b0;
      conv_cnt <= '0;
      vald     <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse even if en drops right after a window.
      vald <= 1'b0;
      if (bus.en) begin
        if (bus.pool_end) begin
          max0     <= PSUM_MIN;
          max1     <= PSUM_MIN;
          max_seen <= 1'b0;
          conv_cnt <= '0;
          beat_cnt <= BEAT_FIRST;
          acc0     <= '0;
          acc1     <= '0;
        end else if (bus.din_valid) begin
          if (beat_cnt == BEAT_LAST) begin
            psum0    <= win0;
            psum1    <= win1;
            max0     <= (win0 > max0) ? win0 : max0;
            max1     <= (win1 > max1) ? win1 : max1;
            max_seen <= 1'b1;
            acc0     <= '0;
            acc1     <= '0;
            beat_cnt <= BEAT_FIRST;
            vald     <= 1'b1;
            conv_cnt <= (conv_cnt == 3'd7) ? conv_cnt : conv_cnt + 3'd1;
          end else begin
            acc0     <= win0;
            acc1     <= win1;
            beat_cnt <= beat_cnt + 2'd1;
          end
        end
      end
    end
  end

  // Max fields read 0 until a window lands in the current pooling group.
  assign bus.Psum_d_out   = {max_seen ? max1 : {PW{1'b0}}, max_seen ? max0 : {PW{1'b0}},
                             psum1, psum0};
  assign bus.conv_counter = conv_cnt;
  assign bus.dout_vald    = vald;
  assign bus.dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_top_conv_layer2.sv
// Bench for top_conv_layer2: directed scenarios plus random traffic, scored
// against an integer window model.
module tb_top_conv_layer2;
  import top_conv_layer2_pkg::*;

  localparam int W       = 4*PW + 3;
  localparam int MAX_MIN = -8388608;

  logic clk = 1'b0;
  logic rst = 1'b1;
  top_conv_layer2_if bus ();
  top_conv_layer2 dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model state ----------------
  logic [ROW_W-1:0]  d_rows[4];
  logic [KROW_W-1:0] f_rows[3];
  int m_acc[2];
  int m_psum[2];
  int m_max[2];
  int m_cnt;
  int m_cc;
  bit m_seen;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] to24(input int v);
    return v[PW-1:0];
  endfunction

  // Contribution of one beat to output row o, from plain integer arithmetic.
  function automatic int term(input int o);
    int s, a, w;
    s = 0;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < LANES; c++) begin
        a = int'(d_rows[o+k][c*AW +: AW]);
        w = int'(f_rows[k][c*WW +: WW]);
        if (w > 7) w = w - 16;
        s += a * w;
      end
    return s;
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [2:0] cc;
    cc = m_cc[2:0];
    return {m_seen ? to24(m_max[1]) : 24'h0, m_seen ? to24(m_max[0]) : 24'h0,
            to24(m_psum[1]), to24(m_psum[0]), cc};
  endfunction

  task automatic model_clear();
    m_acc = '{0, 0};
    m_psum = '{0, 0};
    m_max = '{MAX_MIN, MAX_MIN};
    m_cnt = 0;
    m_cc = 0;
    m_seen = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit valid, input bit pool);
    bus.en = en; bus.din_valid = valid; bus.pool_end = pool;
    bus.data_in_0 = d_rows[0]; bus.data_in_1 = d_rows[1];
    bus.data_in_2 = d_rows[2]; bus.data_in_3 = d_rows[3];
    bus.Filtr_in_0 = f_rows[0]; bus.Filtr_in_1 = f_rows[1]; bus.Filtr_in_2 = f_rows[2];
    if (en) begin
      if (pool) begin
        m_max = '{MAX_MIN, MAX_MIN};
        m_seen = 0; m_cc = 0; m_cnt = 0; m_acc = '{0, 0};
      end else if (valid) begin
        for (int o = 0; o < 2; o++) m_acc[o] += term(o);
        m_cnt++;
        if (m_cnt == KW) begin
          for (int o = 0; o < 2; o++) begin
            m_psum[o] = m_acc[o];
            if (m_acc[o] > m_max[o]) m_max[o] = m_acc[o];
            m_acc[o] = 0;
          end
          m_seen = 1;
          if (m_cc < 7) m_cc++;
          m_cnt = 0;
          exp_q.push_back(model_word());
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.en = 1'b0; bus.din_valid = 1'b0; bus.pool_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic set_uniform(input logic [7:0] d0, input logic [7:0] drest, input logic [3:0] w);
    d_rows[0] = {LANES{d0}};
    for (int r = 1; r < 4; r++) d_rows[r] = {LANES{drest}};
    for (int k = 0; k < 3; k++) f_rows[k] = {LANES{w}};
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.dout_vald) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe actual=%h required=none", bus.Psum_d_out);
        end else begin
          e = exp_q.pop_front();
          check("window", {bus.Psum_d_out, bus.conv_counter}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    logic [47:0] saved;
    logic [63:0] t;
    set_uniform(8'd0, 8'd0, 4'd0);
    reset_dut();
    check("reset_psum", bus.Psum_d_out, '0);
    check("reset_cc", bus.conv_counter, 3'd0);
    check("reset_vald", bus.dout_vald, 1'b0);

    // Row 0 ones, weights +1.
    set_uniform(8'd1, 8'd0, 4'd1);
    beats(3);
    check("t2_vald", bus.dout_vald, 1'b1);
    check("t2_out", bus.Psum_d_out, {24'd0, 24'd36, 24'd0, 24'd36});
    check("t2_cc", bus.conv_counter, 3'd1);
    step(1, 0, 0);
    check("t2_vald_drop", bus.dout_vald, 1'b0);

    // Weights -1 in a fresh pooling group.
    step(1, 0, 1);
    set_uniform(8'd1, 8'd0, 4'hF);
    beats(3);
    check("t3_psum0", bus.Psum_d_out[23:0], 24'hFFFFDC);
    check("t3_max0", bus.Psum_d_out[71:48], 24'hFFFFDC);
    step(1, 0, 0);

    // din_valid toggling, then pool_end.
    step(1, 0, 1);
    set_uniform(8'd1, 8'd0, 4'd1);
    p0 = pulses;
    for (int i = 0; i < 12; i++) step(1, (i % 2) == 0, 0);
    check("t4_pulses", pulses - p0, 2);
    check("t4_cc", bus.conv_counter, 3'd2);
    saved = bus.Psum_d_out[47:0];
    step(1, 0, 1);
    check("t4_pool_cc", bus.conv_counter, 3'd0);
    check("t4_pool_max", bus.Psum_d_out[95:48], 48'd0);
    check("t4_pool_psum", bus.Psum_d_out[47:0], saved);

    // Extreme values.
    set_uniform(8'd255, 8'd255, 4'h8);
    beats(3);
    p0 = -220320;
    check("t5_psum0", bus.Psum_d_out[23:0], to24(p0));
    check("t5_psum1", bus.Psum_d_out[47:24], to24(p0));
    step(1, 0, 0);

    // Partial window discarded by pool_end.
    step(1, 0, 1);
    set_uniform(8'd1, 8'd0, 4'd1);
    beats(2);
    step(1, 1, 1);
    beats(3);
    check("t6_psum0", bus.Psum_d_out[23:0], 24'd36);
    // en low freezes a partial window.
    beats(1);
    step(0, 1, 0);
    check("t6_freeze", bus.dbg_beat_cnt, 2'd1);
    beats(2);
    // Saturation of the window counter.
    for (int i = 0; i < 8; i++) beats(3);
    check("t6_sat", bus.conv_counter, 3'd7);
    step(1, 0, 0);

    // Reset mid-window.
    beats(2);
    reset_dut();
    check("rst_mid_psum", bus.Psum_d_out, '0);
    check("rst_mid_beat", bus.dbg_beat_cnt, 2'd0);
    beats(3);
    check("rst_mid_win", bus.Psum_d_out[23:0], 24'd36);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int r = 0; r < 4; r++) d_rows[r] = {$urandom(), $urandom(), $urandom()};
        for (int k = 0; k < 3; k++) begin
          t = {$urandom(), $urandom()};
          f_rows[k] = t[KROW_W-1:0];
        end
      end
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending windows", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
